// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug command dispatcher.
//   - state_e      : dispatcher FSM states (IDLE, ISSUE, DROP)
//   - cmd_entry_t  : FIFO entry layout (ir, data) at the default widths
//   - calc_ptr_w / calc_cnt_w : width helpers used by modules whose
//     parameters differ from the defaults
//   - PTR_W, CNT_W : widths for the default configuration
// Optional feature macro used elsewhere in the slice: DBG_CMD_PARITY_EN.
package dbg_cmd_pkg;

    localparam int DEF_DATA_W     = 38;
    localparam int DEF_IR_W       = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 255;

    // Pointer width of a power-of-two FIFO; never narrower than 1 bit.
    function automatic int calc_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int calc_cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    localparam int PTR_W = calc_ptr_w(DEF_FIFO_DEPTH);
    localparam int CNT_W = calc_cnt_w(DEF_TIMEOUT);

    // Fixed encodings so the state register stays readable on legacy debug taps.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DROP  = 2'd2
    } state_e;

    // FIFO entry at the default widths; the top declares the same shape at
    // its own parameter widths.
    typedef struct packed {
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_DATA_W-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Parametrised synchronous FIFO with show-ahead read (o_data is the head).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_data : write request / word; accepted when not full, or when
//                    full and popped in the same cycle
//   i_pop          : remove the head (ignored when empty)
//   o_data         : current head word
//   o_full/o_empty : occupancy flags
//   o_level        : occupancy, updated the cycle after push/pop
// DEPTH must be a power of two, >= 2, so pointers wrap naturally.
module dbg_cmd_fifo
    import dbg_cmd_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int         AW       = calc_ptr_w(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level define which
    // entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/dbg_cmd_dispatcher.sv
// Debug command dispatcher: queues clk-domain debug-register updates and
// issues each to one of NUM_CH action channels over valid/ready, with a
// per-command timeout, plus a readback capture mux.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_upd_valid/i_upd_ir/i_upd_data: update word pulse, channel code, payload
//   o_act_valid, i_act_ready       : one-hot command valid, per-channel ready
//   o_act_take, o_act_data         : action flag (payload MSB) and payload
//   i_cap_req, i_cap_sel           : capture request and channel select
//   i_rd_status, o_cap_data        : packed status words, captured word
//   o_cap_valid                    : capture done pulse
//   o_fifo_level                   : command FIFO occupancy
//   o_overrun/o_timeout_err/o_bad_ir: sticky error flags
//   o_parity_err/o_parity_cnt      : parity build only
//   i_clr_err                      : clears sticky flags (a set event wins)
// Optional feature: DBG_CMD_PARITY_EN (bit DATA_W-2 is odd parity over the
// whole word; failing words are dropped and counted).
module dbg_cmd_dispatcher
    import dbg_cmd_pkg::*;
#(
    parameter int DATA_W     = 38,
    parameter int IR_W       = 2,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_W       = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_upd_valid,
    input  logic [IR_W-1:0]               i_upd_ir,
    input  logic [DATA_W-1:0]             i_upd_data,
    output logic [NUM_CH-1:0]             o_act_valid,
    input  logic [NUM_CH-1:0]             i_act_ready,
    output logic                          o_act_take,
    output logic [DATA_W-1:0]             o_act_data,
    input  logic                          i_cap_req,
    input  logic [IR_W-1:0]               i_cap_sel,
    input  logic [NUM_CH*RD_W-1:0]        i_rd_status,
    output logic [RD_W-1:0]               o_cap_data,
    output logic                          o_cap_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overrun,
    output logic                          o_timeout_err,
    output logic                          o_bad_ir,
`ifdef DBG_CMD_PARITY_EN
    output logic                          o_parity_err,
    output logic [7:0]                    o_parity_cnt,
`endif
    input  logic                          i_clr_err
);

    localparam int                 TCW      = calc_cnt_w(TIMEOUT);
    localparam logic [TCW-1:0]     TO_LIMIT = TCW'(TIMEOUT);

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e              r_state;
    logic [NUM_CH-1:0]   r_act_valid;
    logic                r_act_take;
    logic [DATA_W-1:0]   r_act_data;
    logic [TCW-1:0]      r_cnt;
    logic [RD_W-1:0]     r_cap_data;
    logic                r_cap_valid;
    logic                r_overrun;
    logic                r_timeout_err;
    logic                r_bad_ir;

    entry_t              w_push_entry;
    entry_t              w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_ir_ok;
    logic                w_par_ok;
    logic                w_push_req;
    logic                w_ready_hit;
    logic                w_timeout;
    logic                w_pop;
    logic [RD_W-1:0]     w_cap_word;

    assign w_ir_ok      = (int'(i_upd_ir) < NUM_CH);
`ifdef DBG_CMD_PARITY_EN
    assign w_par_ok     = ^i_upd_data;
`else
    assign w_par_ok     = 1'b1;
`endif
    assign w_push_req   = i_upd_valid && w_ir_ok && w_par_ok;
    assign w_push_entry = '{ir: i_upd_ir, data: i_upd_data};

    // r_act_valid is one-hot only while issuing, so masking ready with it
    // ignores every non-selected channel.
    assign w_ready_hit  = (r_state == ISSUE) && |(i_act_ready & r_act_valid);
    assign w_timeout    = (r_state == ISSUE) && (TIMEOUT != 0) && (r_cnt == TO_LIMIT);
    assign w_pop        = w_ready_hit || w_timeout;

    dbg_cmd_fifo #(
        .WIDTH (IR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push_req),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    // Head stays in the FIFO until accepted or timed out, so the output
    // registers hold a stable copy while the command is presented.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_act_valid <= '0;
            r_act_take  <= 1'b0;
            r_act_data  <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_act_valid <= NUM_CH'(1) << w_head.ir;
                        r_act_data  <= w_head.data;
                        r_act_take  <= w_head.data[DATA_W-1];
                        r_cnt       <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_ready_hit) begin
                        r_act_valid <= '0;
                        r_state     <= IDLE;
                    end else if (w_timeout) begin
                        r_act_valid <= '0;
                        r_state     <= DROP;
                    end else if (r_cnt != {TCW{1'b1}}) begin
                        r_cnt <= r_cnt + TCW'(1);
                    end
                end
                DROP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cap_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_cap_sel == IR_W'(k)) w_cap_word = i_rd_status[k*RD_W +: RD_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cap_data  <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_cap_valid <= i_cap_req;
            if (i_cap_req) r_cap_data <= w_cap_word;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_bad_ir      <= 1'b0;
        end else begin
            r_overrun     <= (w_push_req && w_fifo_full && !w_pop) || (r_overrun && !i_clr_err);
            r_timeout_err <= (w_timeout && !w_ready_hit) || (r_timeout_err && !i_clr_err);
            r_bad_ir      <= (i_upd_valid && !w_ir_ok) || (r_bad_ir && !i_clr_err);
        end
    end

`ifdef DBG_CMD_PARITY_EN
    logic       r_parity_err;
    logic [7:0] r_parity_cnt;
    logic       w_par_fail;

    assign w_par_fail = i_upd_valid && !w_par_ok;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_parity_err <= 1'b0;
            r_parity_cnt <= '0;
        end else begin
            r_parity_err <= w_par_fail || (r_parity_err && !i_clr_err);
            if (w_par_fail && r_parity_cnt != 8'hFF) r_parity_cnt <= r_parity_cnt + 8'd1;
        end
    end

    assign o_parity_err = r_parity_err;
    assign o_parity_cnt = r_parity_cnt;
`endif

    assign o_act_valid   = r_act_valid;
    assign o_act_take    = r_act_take;
    assign o_act_data    = r_act_data;
    assign o_cap_data    = r_cap_data;
    assign o_cap_valid   = r_cap_valid;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;
    assign o_bad_ir      = r_bad_ir;

endmodule

// File: tb/tb_dbg_cmd_dispatcher.sv
// Self-checking bench for dbg_cmd_dispatcher (NUM_CH=3, TIMEOUT=3, DEPTH=4).
// Directed scenarios plus randomized traffic, all compared every cycle
// against a transaction-level reference model (command queue + rules).
module tb_dbg_cmd_dispatcher;

    localparam int DATA_W     = 38;
    localparam int IR_W       = 2;
    localparam int NUM_CH     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_W       = 32;
    localparam int TIMEOUT    = 3;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     upd_valid;
    logic [IR_W-1:0]          upd_ir;
    logic [DATA_W-1:0]        upd_data;
    logic [NUM_CH-1:0]        act_valid;
    logic [NUM_CH-1:0]        act_ready;
    logic                     act_take;
    logic [DATA_W-1:0]        act_data;
    logic                     cap_req;
    logic [IR_W-1:0]          cap_sel;
    logic [NUM_CH*RD_W-1:0]   rd_status;
    logic [RD_W-1:0]          cap_data;
    logic                     cap_valid;
    logic [LVL_W-1:0]         fifo_level;
    logic                     overrun;
    logic                     timeout_err;
    logic                     bad_ir;
    logic                     clr_err;
`ifdef DBG_CMD_PARITY_EN
    logic                     parity_err;
    logic [7:0]               parity_cnt;
`endif

    dbg_cmd_dispatcher #(
        .DATA_W(DATA_W), .IR_W(IR_W), .NUM_CH(NUM_CH),
        .FIFO_DEPTH(FIFO_DEPTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_upd_valid   (upd_valid),
        .i_upd_ir      (upd_ir),
        .i_upd_data    (upd_data),
        .o_act_valid   (act_valid),
        .i_act_ready   (act_ready),
        .o_act_take    (act_take),
        .o_act_data    (act_data),
        .i_cap_req     (cap_req),
        .i_cap_sel     (cap_sel),
        .i_rd_status   (rd_status),
        .o_cap_data    (cap_data),
        .o_cap_valid   (cap_valid),
        .o_fifo_level  (fifo_level),
        .o_overrun     (overrun),
        .o_timeout_err (timeout_err),
        .o_bad_ir      (bad_ir),
`ifdef DBG_CMD_PARITY_EN
        .o_parity_err  (parity_err),
        .o_parity_cnt  (parity_cnt),
`endif
        .i_clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              m_q[$];        // queued commands; m_q[0] is presented when m_presenting
    bit                m_presenting;
    bit                m_hold;        // one dead cycle after a timeout drop
    int                m_age;         // cycles the current command has been presented
    logic [DATA_W-1:0] m_data;
    bit                m_over, m_tmo, m_bad, m_cap_valid;
    logic [RD_W-1:0]   m_cap_data;
    bit                m_par_err;
    int                m_par_cnt;

    task automatic model_edge();
        bit   ready_hit, tmo, ir_ok, par_ok, wants, accepted;
        int   pre_size;
        cmd_t c;
        if (reset) begin
            m_q.delete();
            m_presenting = 0; m_hold = 0; m_age = 0; m_data = '0;
            m_over = 0; m_tmo = 0; m_bad = 0; m_cap_valid = 0; m_cap_data = '0;
            m_par_err = 0; m_par_cnt = 0;
            return;
        end
        m_cap_valid = cap_req;
        if (cap_req) m_cap_data = (int'(cap_sel) < NUM_CH) ? rd_status[int'(cap_sel)*RD_W +: RD_W] : '0;

        ready_hit = m_presenting && act_ready[m_q[0].ir];
        tmo       = m_presenting && !ready_hit && (m_age == TIMEOUT);
        pre_size  = m_q.size();
        ir_ok     = int'(upd_ir) < NUM_CH;
`ifdef DBG_CMD_PARITY_EN
        par_ok    = ^upd_data;
`else
        par_ok    = 1;
`endif
        wants     = upd_valid && ir_ok && par_ok;
        accepted  = wants && (pre_size < FIFO_DEPTH || ready_hit || tmo);

        if (m_presenting) begin
            if (ready_hit || tmo) begin
                void'(m_q.pop_front());
                m_presenting = 0;
                m_hold = tmo;
            end else begin
                m_age++;
            end
        end else if (m_hold) begin
            m_hold = 0;
        end else if (pre_size > 0) begin
            m_presenting = 1;
            m_age = 0;
            m_data = m_q[0].data;
        end
        if (accepted) begin
            c.ir = upd_ir; c.data = upd_data;
            m_q.push_back(c);
        end

        m_over    = (wants && !accepted) || (m_over && !clr_err);
        m_tmo     = tmo || (m_tmo && !clr_err);
        m_bad     = (upd_valid && !ir_ok) || (m_bad && !clr_err);
        m_par_err = (upd_valid && !par_ok) || (m_par_err && !clr_err);
        if (upd_valid && !par_ok && m_par_cnt < 255) m_par_cnt++;
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] exp_valid;
        exp_valid = m_presenting ? NUM_CH'(1 << m_q[0].ir) : '0;
        check("act_valid",   64'(act_valid),   64'(exp_valid));
        check("act_data",    64'(act_data),    64'(m_data));
        check("act_take",    64'(act_take),    64'(m_data[DATA_W-1]));
        check("fifo_level",  64'(fifo_level),  64'(m_q.size()));
        check("overrun",     64'(overrun),     64'(m_over));
        check("timeout_err", 64'(timeout_err), 64'(m_tmo));
        check("bad_ir",      64'(bad_ir),      64'(m_bad));
        check("cap_valid",   64'(cap_valid),   64'(m_cap_valid));
        check("cap_data",    64'(cap_data),    64'(m_cap_data));
`ifdef DBG_CMD_PARITY_EN
        check("parity_err",  64'(parity_err),  64'(m_par_err));
        check("parity_cnt",  64'(parity_cnt),  64'(m_par_cnt));
`endif
    endtask

    // One clock: inputs set before the edge, model advanced, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [DATA_W-1:0] rand_raw();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    // Returns a word that passes the input parity rule of the build.
    function automatic logic [DATA_W-1:0] make_word(input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] w;
        w = raw;
`ifdef DBG_CMD_PARITY_EN
        w[DATA_W-2] = 1'b0;
        if (^w == 1'b0) w[DATA_W-2] = 1'b1;
`endif
        return w;
    endfunction

    task automatic drain();
        act_ready = '1; upd_valid = 0; clr_err = 0; cap_req = 0;
        for (int i = 0; i < 60 && (fifo_level != 0 || act_valid != 0); i++) step();
        check("drain_level", 64'(fifo_level), 64'(0));
        act_ready = '0;
        clr_err = 1; step(); clr_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1; upd_valid = 0; upd_ir = '0; upd_data = '0; act_ready = '0;
        cap_req = 0; cap_sel = '0; rd_status = '0; clr_err = 0;
        step(); step();
        reset = 0;
        check("rst_act_valid", 64'(act_valid), 64'(0));
        check("rst_level",     64'(fifo_level), 64'(0));
        check("rst_flags",     64'({overrun, timeout_err, bad_ir, cap_valid}), 64'(0));

        // Single command: 2-cycle latency, then accepted by channel 2.
        upd_valid = 1; upd_ir = 2; upd_data = make_word(38'h20_0000_0005);
        step();
        upd_valid = 0;
        step();
        check("t1_valid", 64'(act_valid), 64'(3'b100));
        check("t1_take",  64'(act_take),  64'(1));
        check("t1_data",  64'(act_data),  64'(38'h20_0000_0005));
        act_ready = 3'b100;
        step();
        act_ready = '0;
        check("t1_drop_valid", 64'(act_valid), 64'(0));
        check("t1_level",      64'(fifo_level), 64'(0));

        // Overrun: 5 pushes into a 4-deep FIFO with no ready.
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1; upd_ir = IR_W'(i % NUM_CH); upd_data = make_word(rand_raw());
            step();
        end
        upd_valid = 0;
        check("t2_level_full", 64'(fifo_level), 64'(4));
        check("t2_overrun",    64'(overrun),    64'(1));
        clr_err = 1; step(); clr_err = 0;
        check("t2_clr", 64'(overrun), 64'(0));
        upd_valid = 1; upd_ir = 0; upd_data = make_word(rand_raw());
        step();
        clr_err = 1;
        step();
        upd_valid = 0; clr_err = 0;
        check("t2_set_wins", 64'(overrun), 64'(1));
        drain();

        // Timeout: two commands, no ready; first is presented 4 cycles.
        upd_valid = 1; upd_ir = 0; upd_data = make_word(rand_raw()); step();
        upd_ir = 1; upd_data = make_word(rand_raw()); step();
        upd_valid = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (act_valid == 3'b001) cnt++;
            if (act_valid == 3'b010) break;
            step();
        end
        check("t3_valid_cycles", 64'(cnt), 64'(4));
        check("t3_timeout_err",  64'(timeout_err), 64'(1));
        check("t3_next_issued",  64'(act_valid), 64'(3'b010));
        act_ready = 3'b010; step(); act_ready = '0;
        drain();

        // Out-of-range instruction code.
        upd_valid = 1; upd_ir = 3; upd_data = make_word(rand_raw()); step();
        upd_valid = 0;
        check("t4_bad_ir", 64'(bad_ir), 64'(1));
        check("t4_level",  64'(fifo_level), 64'(0));
        clr_err = 1; step(); clr_err = 0;

        // Capture while a command is pending in ISSUE, then out-of-range select.
        upd_valid = 1; upd_ir = 1; upd_data = make_word(rand_raw()); step();
        upd_ir = 2; upd_data = make_word(rand_raw()); step();
        upd_valid = 0;
        rd_status = {32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        cap_req = 1; cap_sel = 1; step();
        cap_req = 0;
        check("t5_cap_data",  64'(cap_data),  64'(32'hDEAD_BEEF));
        check("t5_cap_valid", 64'(cap_valid), 64'(1));
        check("t5_pending",   64'(act_valid), 64'(3'b010));
        cap_req = 1; cap_sel = 3; step(); cap_req = 0;
        check("t5_cap_oob", 64'(cap_data), 64'(0));

        // Reset while issuing discards the FIFO.
        reset = 1; step(); reset = 0;
        check("t6_valid", 64'(act_valid), 64'(0));
        check("t6_level", 64'(fifo_level), 64'(0));
        step();

`ifdef DBG_CMD_PARITY_EN
        // Bad parity dropped and counted; good word still dispatched.
        upd_valid = 1; upd_ir = 0;
        upd_data = make_word(rand_raw()); upd_data[DATA_W-2] = ~upd_data[DATA_W-2];
        step();
        upd_valid = 0;
        check("tp_err",   64'(parity_err), 64'(1));
        check("tp_cnt",   64'(parity_cnt), 64'(1));
        check("tp_level", 64'(fifo_level), 64'(0));
        upd_valid = 1; upd_data = make_word(rand_raw()); step();
        upd_valid = 0; step();
        check("tp_good_valid", 64'(act_valid), 64'(3'b001));
        drain();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 249) == 0);
            upd_valid = ($urandom_range(0, 2) != 0);
            upd_ir    = IR_W'($urandom_range(0, 3));
            upd_data  = make_word(rand_raw());
`ifdef DBG_CMD_PARITY_EN
            if ($urandom_range(0, 7) == 0) upd_data[DATA_W-2] = ~upd_data[DATA_W-2];
`endif
            act_ready = NUM_CH'($urandom_range(0, 7) & $urandom_range(0, 7));
            clr_err   = ($urandom_range(0, 15) == 0);
            cap_req   = ($urandom_range(0, 3) == 0);
            cap_sel   = IR_W'($urandom_range(0, 3));
            rd_status = {$urandom, $urandom, $urandom};
            step();
        end
        reset = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
